// File: rtl/ex_pkg.sv
// Shared opcodes, register-destination encodings and fixed register
// indices for the execute stage.
package ex_pkg;

   localparam logic [5:0] ALU_ADD   = 6'd0;
   localparam logic [5:0] ALU_ADDU  = 6'd1;
   localparam logic [5:0] ALU_SUB   = 6'd2;
   localparam logic [5:0] ALU_SUBU  = 6'd3;
   localparam logic [5:0] ALU_AND   = 6'd4;
   localparam logic [5:0] ALU_OR    = 6'd5;
   localparam logic [5:0] ALU_XOR   = 6'd6;
   localparam logic [5:0] ALU_NOR   = 6'd7;
   localparam logic [5:0] ALU_SLT   = 6'd8;
   localparam logic [5:0] ALU_SLL   = 6'd9;
   localparam logic [5:0] ALU_SRL   = 6'd10;
   localparam logic [5:0] ALU_SRA   = 6'd11;
   localparam logic [5:0] ALU_LUI   = 6'd12;

   localparam logic [5:0] ALU_MULT  = 6'd16;
   localparam logic [5:0] ALU_MULTU = 6'd17;
   localparam logic [5:0] ALU_DIV   = 6'd18;
   localparam logic [5:0] ALU_DIVU  = 6'd19;
   localparam logic [5:0] ALU_MFHI  = 6'd20;
   localparam logic [5:0] ALU_MFLO  = 6'd21;
   localparam logic [5:0] ALU_MTHI  = 6'd22;
   localparam logic [5:0] ALU_MTLO  = 6'd23;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;
   localparam logic [1:0] RDST_K0 = 2'b11;

   localparam int REG_RA = 31;
   localparam int REG_K0 = 26;

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX bundle, forwarding bus and EX/MEM outputs of the execute stage.
// master = ID/MEM side, slave = execute stage.
interface ex_stage_mdu_if #(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int NFWD = 2
);
   logic              id_valid;
   logic              id_ready;
   logic              flush;
   logic [5:0]        id_aluctl;
   logic              id_alusign;
   logic              id_alusrc1;
   logic              id_alusrc2;
   logic [1:0]        id_regdst;
   logic [XLEN-1:0]   id_shamt;
   logic [XLEN-1:0]   id_imm;
   logic [REGW-1:0]   id_rs;
   logic [REGW-1:0]   id_rt;
   logic [REGW-1:0]   id_rd;
   logic [XLEN-1:0]   id_rsdata;
   logic [XLEN-1:0]   id_rtdata;
   logic              id_memwrite;
   logic              id_regwrite;
   logic [1:0]        id_memtoreg;
   logic [XLEN-1:0]   id_pc4;
   logic [NFWD-1:0]   fwd_we;
   logic [NFWD*REGW-1:0] fwd_addr;
   logic [NFWD*XLEN-1:0] fwd_data;
   logic [REGW-1:0]   ex_wreg;
   logic              out_ready;
   logic              out_valid;
   logic [XLEN-1:0]   out_alu;
   logic [XLEN-1:0]   out_wdata;
   logic [XLEN-1:0]   out_pc4;
   logic [REGW-1:0]   out_wreg;
   logic              out_memwrite;
   logic              out_regwrite;
   logic [1:0]        out_memtoreg;
   logic              mdu_busy;

   modport master (
      output id_valid, flush, id_aluctl, id_alusign,
      output id_alusrc1, id_alusrc2, id_regdst,
      output id_shamt, id_imm, id_rs, id_rt, id_rd,
      output id_rsdata, id_rtdata, id_memwrite,
      output id_regwrite, id_memtoreg, id_pc4,
      output fwd_we, fwd_addr, fwd_data, out_ready,
      input  id_ready, ex_wreg, out_valid, out_alu,
      input  out_wdata, out_pc4, out_wreg,
      input  out_memwrite, out_regwrite, out_memtoreg,
      input  mdu_busy
   );

   modport slave (
      input  id_valid, flush, id_aluctl, id_alusign,
      input  id_alusrc1, id_alusrc2, id_regdst,
      input  id_shamt, id_imm, id_rs, id_rt, id_rd,
      input  id_rsdata, id_rtdata, id_memwrite,
      input  id_regwrite, id_memtoreg, id_pc4,
      input  fwd_we, fwd_addr, fwd_data, out_ready,
      output id_ready, ex_wreg, out_valid, out_alu,
      output out_wdata, out_pc4, out_wreg,
      output out_memwrite, out_regwrite, out_memtoreg,
      output mdu_busy
   );
endinterface

// File: rtl/ex_alu.sv
// Combinational integer ALU: add/sub, logic, set-less-than and shifts.
module ex_alu
   import ex_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [5:0]      ctl,
   input  logic            sign,
   output logic [XLEN-1:0] y
);
   localparam int SW = $clog2(XLEN);

   logic [SW-1:0] sh;
   logic          lt;

   assign sh = a[SW-1:0];

   always_comb begin
      lt = sign ? ($signed(a) < $signed(b)) : (a < b);
      y  = '0;
      case (ctl)
         ALU_ADD, ALU_ADDU: y = a + b;
         ALU_SUB, ALU_SUBU: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_NOR: y = ~(a | b);
         ALU_SLT: y = {{(XLEN-1){1'b0}}, lt};
         ALU_SLL: y = b << sh;
         ALU_SRL: y = b >> sh;
         ALU_SRA: y = $signed(b) >>> sh;
         ALU_LUI: y = b << (XLEN / 2);
         default: y = '0;
      endcase
   end
endmodule

// File: rtl/ex_mdu.sv
// Iterative multiply/divide unit with HI/LO: shift-add multiply and
// restoring divide on magnitudes, one bit per cycle, sign fixed at the end.
module ex_mdu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            isDiv,
   input  logic            sign,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            hiWe,
   input  logic            loWe,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);
   localparam int CW = $clog2(XLEN + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] wHi, wLo, opnd;
   logic            divOp, negQ, negR;

   logic            aNeg, bNeg;
   logic [XLEN-1:0] aMag, bMag;
   logic [XLEN:0]   sum, shv, diff;
   logic            ge;
   logic [XLEN-1:0] nHi, nLo, fHi, fLo;
   logic [2*XLEN-1:0] prod;

   assign aNeg = sign & a[XLEN-1];
   assign bNeg = sign & b[XLEN-1];
   assign aMag = aNeg ? -a : a;
   assign bMag = bNeg ? -b : b;

   always_comb begin
      sum  = {1'b0, wHi} + (wLo[0] ? {1'b0, opnd} : '0);
      shv  = {wHi, wLo[XLEN-1]};
      diff = shv - {1'b0, opnd};
      ge   = ~diff[XLEN];
      if (divOp) begin
         nHi = ge ? diff[XLEN-1:0] : shv[XLEN-1:0];
         nLo = {wLo[XLEN-2:0], ge};
      end else begin
         nHi = sum[XLEN:1];
         nLo = {sum[0], wLo[XLEN-1:1]};
      end
      prod = {nHi, nLo};
      if (negQ) prod = -prod;
      if (divOp) begin
         fHi = negR ? -nHi : nHi;
         fLo = negQ ? -nLo : nLo;
      end else begin
         fHi = prod[2*XLEN-1:XLEN];
         fLo = prod[XLEN-1:0];
      end
   end

   // Divide by zero keeps the all-ones quotient unsigned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         wHi   <= '0;
         wLo   <= '0;
         opnd  <= '0;
         divOp <= 1'b0;
         negQ  <= 1'b0;
         negR  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= BUSY;
                  busy  <= 1'b1;
                  cnt   <= CW'(XLEN);
                  divOp <= isDiv;
                  wHi   <= '0;
                  wLo   <= aMag;
                  opnd  <= bMag;
                  negQ  <= (aNeg ^ bNeg) & (~isDiv | (|b));
                  negR  <= aNeg;
               end else begin
                  if (hiWe) hi <= wdata;
                  if (loWe) lo <= wdata;
               end
            end
            BUSY: begin
               cnt <= cnt - CW'(1);
               wHi <= nHi;
               wLo <= nLo;
               if (cnt == CW'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  hi    <= fHi;
                  lo    <= fLo;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: rtl/ex_stage_mdu.sv
// Execute stage: operand forwarding, ALU, iterative MDU with HI/LO
// interlock, and the EX/MEM register behind a valid/ready handshake.
module ex_stage_mdu
   import ex_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int NFWD = 2
) (
   input logic clk,
   input logic rst_n,
   ex_stage_mdu_if.slave bus
);
   logic [XLEN-1:0] rsVal, rtVal, opA, opB, aluY, res, hi, lo;
   logic [REGW-1:0] wreg;
   logic isStart, isDivOp, isMfhi, isMflo, isMthi, isMtlo, isMdu;
   logic busy, ready, accept;

   logic            oValid, oMemwrite, oRegwrite;
   logic [1:0]      oMemtoreg;
   logic [XLEN-1:0] oAlu, oWdata, oPc4;
   logic [REGW-1:0] oWreg;

   // Iterate oldest-first so the lowest matching index wins.
   always_comb begin
      rsVal = bus.id_rsdata;
      rtVal = bus.id_rtdata;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (bus.fwd_we[i] && bus.id_rs != '0 &&
             bus.fwd_addr[i*REGW +: REGW] == bus.id_rs)
            rsVal = bus.fwd_data[i*XLEN +: XLEN];
         if (bus.fwd_we[i] && bus.id_rt != '0 &&
             bus.fwd_addr[i*REGW +: REGW] == bus.id_rt)
            rtVal = bus.fwd_data[i*XLEN +: XLEN];
      end
   end

   assign opA = bus.id_alusrc1 ? bus.id_shamt : rsVal;
   assign opB = bus.id_alusrc2 ? bus.id_imm : rtVal;

   always_comb begin
      isStart = 1'b0;
      isDivOp = 1'b0;
      isMfhi  = 1'b0;
      isMflo  = 1'b0;
      isMthi  = 1'b0;
      isMtlo  = 1'b0;
      unique case (1'b1)
         (bus.id_aluctl == ALU_MULT) ||
         (bus.id_aluctl == ALU_MULTU): isStart = 1'b1;
         (bus.id_aluctl == ALU_DIV) ||
         (bus.id_aluctl == ALU_DIVU): begin
            isStart = 1'b1;
            isDivOp = 1'b1;
         end
         bus.id_aluctl == ALU_MFHI: isMfhi = 1'b1;
         bus.id_aluctl == ALU_MFLO: isMflo = 1'b1;
         bus.id_aluctl == ALU_MTHI: isMthi = 1'b1;
         bus.id_aluctl == ALU_MTLO: isMtlo = 1'b1;
         default: ;
      endcase
      isMdu = isStart | isMfhi | isMflo | isMthi | isMtlo;
   end

   always_comb begin
      wreg = bus.id_rt;
      unique case (bus.id_regdst)
         RDST_RT: wreg = bus.id_rt;
         RDST_RD: wreg = bus.id_rd;
         RDST_RA: wreg = REGW'(REG_RA);
         RDST_K0: wreg = REGW'(REG_K0);
         default: wreg = bus.id_rt;
      endcase
   end

   assign ready  = (~oValid | bus.out_ready) & ~(isMdu & busy);
   assign accept = bus.id_valid & ready & ~bus.flush;

   ex_alu #(.XLEN(XLEN)) uAlu (
      .a    (opA),
      .b    (opB),
      .ctl  (bus.id_aluctl),
      .sign (bus.id_alusign),
      .y    (aluY)
   );

   ex_mdu #(.XLEN(XLEN)) uMdu (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept & isStart),
      .isDiv (isDivOp),
      .sign  (bus.id_alusign),
      .a     (rsVal),
      .b     (rtVal),
      .hiWe  (accept & isMthi),
      .loWe  (accept & isMtlo),
      .wdata (rsVal),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always_comb begin
      res = aluY;
      if (isMfhi) res = hi;
      else if (isMflo) res = lo;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         oValid    <= 1'b0;
         oAlu      <= '0;
         oWdata    <= '0;
         oPc4      <= '0;
         oWreg     <= '0;
         oMemwrite <= 1'b0;
         oRegwrite <= 1'b0;
         oMemtoreg <= '0;
      end else if (accept) begin
         oValid    <= 1'b1;
         oAlu      <= res;
         oWdata    <= rtVal;
         oPc4      <= bus.id_pc4;
         oWreg     <= wreg;
         oMemwrite <= bus.id_memwrite;
         oRegwrite <= bus.id_regwrite &
                      ~(isStart | isMthi | isMtlo);
         oMemtoreg <= bus.id_memtoreg;
      end else if (bus.out_ready) begin
         oValid <= 1'b0;
      end
   end

   assign bus.id_ready     = ready;
   assign bus.ex_wreg      = wreg;
   assign bus.mdu_busy     = busy;
   assign bus.out_valid    = oValid;
   assign bus.out_alu      = oAlu;
   assign bus.out_wdata    = oWdata;
   assign bus.out_pc4      = oPc4;
   assign bus.out_wreg     = oWreg;
   assign bus.out_memwrite = oMemwrite;
   assign bus.out_regwrite = oRegwrite;
   assign bus.out_memtoreg = oMemtoreg;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed bench for ex_stage_mdu: vector table for forwarding/ALU,
// hand sequences for MDU latency, interlock, hold, flush and reset.
module tb_ex_stage_mdu;
   import ex_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ex_stage_mdu_if #(.XLEN(32), .REGW(5), .NFWD(2)) bus ();

   ex_stage_mdu #(.XLEN(32), .REGW(5), .NFWD(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int nTests = 0;
   int nFail  = 0;

   typedef struct packed {
      logic [5:0]  op;
      logic        sgn;
      logic        s1;
      logic        s2;
      logic [1:0]  rdst;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [31:0] rsd;
      logic [31:0] rtd;
      logic [31:0] shamt;
      logic [31:0] imm;
      logic [1:0]  we;
      logic [4:0]  a0;
      logic [4:0]  a1;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [31:0] eAlu;
      logic [31:0] eWdata;
      logic [4:0]  eWreg;
   } vec_t;

   vec_t vecs[13];

   function automatic vec_t mk(input logic [5:0] op, input logic sgn,
                               input logic [31:0] a, input logic [31:0] b);
      vec_t v = '0;
      v.op = op; v.sgn = sgn;
      v.rs = 5'd1; v.rt = 5'd2; v.rd = 5'd3;
      v.rdst = RDST_RD;
      v.rsd = a; v.rtd = b;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.id_aluctl  = v.op;
      bus.id_alusign = v.sgn;
      bus.id_alusrc1 = v.s1;
      bus.id_alusrc2 = v.s2;
      bus.id_regdst  = v.rdst;
      bus.id_shamt   = v.shamt;
      bus.id_imm     = v.imm;
      bus.id_rs      = v.rs;
      bus.id_rt      = v.rt;
      bus.id_rd      = v.rd;
      bus.id_rsdata  = v.rsd;
      bus.id_rtdata  = v.rtd;
      bus.fwd_we     = v.we;
      bus.fwd_addr   = {v.a1, v.a0};
      bus.fwd_data   = {v.d1, v.d0};
      bus.id_memwrite = 1'b0;
      bus.id_regwrite = 1'b1;
      bus.id_memtoreg = 2'b00;
      bus.id_pc4      = 32'h0000_0400;
   endtask

   task automatic send(input vec_t v, output int stall);
      drive(v);
      bus.id_valid = 1'b1;
      stall = 0;
      @(negedge clk);
      while (!bus.id_ready && stall < 200) begin
         stall++;
         @(negedge clk);
      end
      if (stall >= 200) begin
         nTests++;
         nFail++;
         $display("FAIL send_timeout: id_ready low %0d cycles, required high", stall);
      end
      @(posedge clk);
      #1;
      bus.id_valid = 1'b0;
   endtask

   task automatic mf(input string nm, input logic [5:0] op,
                     input logic [31:0] exp, input int expStall);
      int st;
      send(mk(op, 1'b0, 32'h0, 32'h0), st);
      if (expStall >= 0) chk({nm, "_stall"}, 32'(st), 32'(expStall));
      @(negedge clk);
      chk(nm, bus.out_alu, exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int st;
      int n;

      vecs[0]  = '{ALU_ADD, 1'b1, 1'b0, 1'b0, RDST_RD, 5'd5, 5'd6, 5'd7,
                   32'h1234, 32'h1, 32'h0, 32'h0, 2'b11, 5'd5, 5'd5,
                   32'hAAAA, 32'hBBBB, 32'hAAAB, 32'h1, 5'd7};
      vecs[1]  = '{ALU_ADD, 1'b1, 1'b0, 1'b0, RDST_RD, 5'd0, 5'd6, 5'd7,
                   32'h0, 32'h1, 32'h0, 32'h0, 2'b11, 5'd0, 5'd0,
                   32'hAAAA, 32'hBBBB, 32'h1, 32'h1, 5'd7};
      vecs[2]  = '{ALU_ADD, 1'b1, 1'b0, 1'b0, RDST_RD, 5'd5, 5'd6, 5'd7,
                   32'h1234, 32'h1, 32'h0, 32'h0, 2'b10, 5'd5, 5'd5,
                   32'hAAAA, 32'hBBBB, 32'hBBBC, 32'h1, 5'd7};
      vecs[3]  = '{ALU_ADDU, 1'b0, 1'b0, 1'b1, RDST_RT, 5'd3, 5'd6, 5'd7,
                   32'h64, 32'h99, 32'h0, 32'h20, 2'b01, 5'd6, 5'd0,
                   32'h55, 32'h0, 32'h84, 32'h55, 5'd6};
      vecs[4]  = '{ALU_SUB, 1'b1, 1'b0, 1'b0, RDST_RA, 5'd1, 5'd2, 5'd3,
                   32'h5, 32'h7, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hFFFF_FFFE, 32'h7, 5'd31};
      vecs[5]  = '{ALU_SLT, 1'b1, 1'b0, 1'b0, RDST_K0, 5'd1, 5'd2, 5'd3,
                   32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h1, 32'h1, 5'd26};
      vecs[6]  = '{ALU_SLT, 1'b0, 1'b0, 1'b0, RDST_K0, 5'd1, 5'd2, 5'd3,
                   32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h0, 32'h1, 5'd26};
      vecs[7]  = '{ALU_SRA, 1'b0, 1'b1, 1'b0, RDST_RT, 5'd1, 5'd2, 5'd3,
                   32'h0, 32'h8000_0000, 32'h4, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hF800_0000, 32'h8000_0000, 5'd2};
      vecs[8]  = '{ALU_SLL, 1'b0, 1'b1, 1'b0, RDST_RT, 5'd1, 5'd2, 5'd3,
                   32'h0, 32'hFF, 32'h8, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hFF00, 32'hFF, 5'd2};
      vecs[9]  = '{ALU_LUI, 1'b0, 1'b0, 1'b1, RDST_RT, 5'd0, 5'd2, 5'd3,
                   32'h0, 32'h0, 32'h0, 32'h1234, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h1234_0000, 32'h0, 5'd2};
      vecs[10] = '{ALU_NOR, 1'b0, 1'b0, 1'b0, RDST_RD, 5'd1, 5'd2, 5'd3,
                   32'h0, 32'h0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 5'd3};
      vecs[11] = '{ALU_AND, 1'b0, 1'b0, 1'b0, RDST_RD, 5'd1, 5'd2, 5'd3,
                   32'hF0F0, 32'h0FF0, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h00F0, 32'h0FF0, 5'd3};
      vecs[12] = '{ALU_SRL, 1'b0, 1'b1, 1'b0, RDST_RT, 5'd1, 5'd2, 5'd3,
                   32'h0, 32'h8000_0000, 32'd31, 32'h0, 2'b00, 5'd0, 5'd0,
                   32'h0, 32'h0, 32'h1, 32'h8000_0000, 5'd2};

      drive('0);
      bus.id_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      @(negedge clk);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_alu", bus.out_alu, 32'h0);
      chk("rst_busy", 32'(bus.mdu_busy), 32'h0);
      chk("rst_id_ready", 32'(bus.id_ready), 32'h1);

      for (int i = 0; i < 13; i++) begin
         drive(vecs[i]);
         bus.id_valid = 1'b1;
         @(negedge clk);
         chk($sformatf("v%0d_ex_wreg", i), 32'(bus.ex_wreg), 32'(vecs[i].eWreg));
         chk($sformatf("v%0d_ready", i), 32'(bus.id_ready), 32'h1);
         @(posedge clk);
         #1 bus.id_valid = 1'b0;
         @(negedge clk);
         chk($sformatf("v%0d_alu", i), bus.out_alu, vecs[i].eAlu);
         chk($sformatf("v%0d_wdata", i), bus.out_wdata, vecs[i].eWdata);
         chk($sformatf("v%0d_wreg", i), 32'(bus.out_wreg), 32'(vecs[i].eWreg));
         chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'h1);
      end

      // Downstream stall holds EX/MEM and blocks the next bundle.
      send(mk(ALU_ADD, 1'b1, 32'd1, 32'd2), st);
      @(negedge clk);
      chk("hold_first", bus.out_alu, 32'd3);
      bus.out_ready = 1'b0;
      drive(mk(ALU_ADD, 1'b1, 32'd4, 32'd5));
      bus.id_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("hold_ready", 32'(bus.id_ready), 32'h0);
         chk("hold_alu", bus.out_alu, 32'd3);
         chk("hold_valid", 32'(bus.out_valid), 32'h1);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("release_ready", 32'(bus.id_ready), 32'h1);
      @(posedge clk);
      #1 bus.id_valid = 1'b0;
      @(negedge clk);
      chk("release_alu", bus.out_alu, 32'd9);

      // Flush of a plain bundle and of an MDU start.
      drive(mk(ALU_ADD, 1'b1, 32'd1, 32'd1));
      bus.id_valid = 1'b1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.id_valid = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(bus.out_valid), 32'h0);
      chk("flush_alu_held", bus.out_alu, 32'd9);
      drive(mk(ALU_MULTU, 1'b0, 32'd6, 32'd7));
      bus.id_valid = 1'b1;
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.id_valid = 1'b0;
      bus.flush = 1'b0;
      @(negedge clk);
      chk("flush_no_start", 32'(bus.mdu_busy), 32'h0);

      send(mk(ALU_MULTU, 1'b0, 32'd6, 32'd7), st);
      @(negedge clk);
      chk("mult_busy", 32'(bus.mdu_busy), 32'h1);
      chk("mult_regwrite", 32'(bus.out_regwrite), 32'h0);
      drive(mk(ALU_ADD, 1'b1, 32'd1, 32'd1));
      bus.id_valid = 1'b1;
      bus.flush = 1'b1;
      repeat (2) @(posedge clk);
      #1 bus.id_valid = 1'b0;
      bus.flush = 1'b0;
      mf("flushmul_lo", ALU_MFLO, 32'd42, -1);
      mf("flushmul_hi", ALU_MFHI, 32'd0, 0);

      // Back-to-back MDU ops, then signed multiply.
      send(mk(ALU_MULTU, 1'b0, 32'd6, 32'd7), st);
      send(mk(ALU_MULT, 1'b1, 32'hFFFF_FFFD, 32'd7), st);
      chk("b2b_stall", 32'(st), 32'd32);
      mf("mult_lo", ALU_MFLO, 32'hFFFF_FFEB, 32);
      mf("mult_hi", ALU_MFHI, 32'hFFFF_FFFF, 0);

      send(mk(ALU_DIV, 1'b1, 32'd7, 32'd0), st);
      mf("div0_hi", ALU_MFHI, 32'd7, 32);
      mf("div0_lo", ALU_MFLO, 32'hFFFF_FFFF, 0);

      send(mk(ALU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2), st);
      mf("divs_lo", ALU_MFLO, 32'hFFFF_FFFD, 32);
      mf("divs_hi", ALU_MFHI, 32'hFFFF_FFFF, 0);

      send(mk(ALU_DIVU, 1'b0, 32'd100, 32'd7), st);
      mf("divu_lo", ALU_MFLO, 32'd14, 32);
      mf("divu_hi", ALU_MFHI, 32'd2, 0);

      send(mk(ALU_MTHI, 1'b0, 32'h1234_5678, 32'h0), st);
      mf("mthi", ALU_MFHI, 32'h1234_5678, 0);
      send(mk(ALU_MTLO, 1'b0, 32'hCAFE_0001, 32'h0), st);
      mf("mtlo", ALU_MFLO, 32'hCAFE_0001, 0);

      // Reset in the middle of a divide.
      send(mk(ALU_DIVU, 1'b0, 32'd100, 32'd7), st);
      repeat (10) @(negedge clk);
      chk("mid_div_busy", 32'(bus.mdu_busy), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_busy", 32'(bus.mdu_busy), 32'h0);
      chk("rst_mid_valid", 32'(bus.out_valid), 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      mf("rst_hi", ALU_MFHI, 32'd0, 0);
      mf("rst_lo", ALU_MFLO, 32'd0, 0);

      send(mk(ALU_MULT, 1'b1, 32'd3, 32'd5), st);
      n = 0;
      @(negedge clk);
      while (bus.mdu_busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("post_rst_latency", 32'(n), 32'd32);
      mf("post_rst_lo", ALU_MFLO, 32'd15, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end
endmodule

// File: doc/ex_stage_mdu.md
# ex_stage_mdu

Parametrised execute stage for the five-stage MIPS pipeline, sitting between the ID/EX bundle and the EX/MEM register. It replaces the fixed two-source EX stage with several changes:
- configurable data width and number of forwarding sources;
- a valid/ready handshake on both sides, with downstream stall and flush;
- an iterative multiply/divide unit (MDU) with HI/LO registers and interlock.

## Interface
- XLEN, 32, datapath width (even, ≥8)
- REGW, 5, register-index width
- NFWD, 2, forwarding sources; index 0 = youngest (MEM), highest priority

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID/EX bundle valid
- id_ready  out  1  EX accepts bundle this cycle
- flush  in  1  discard the ID/EX bundle presented this cycle
- id_aluctl  in  6  operation code; MDU ops from shared package
- id_alusign  in  1  signed compare/overflow, signed MDU
- id_alusrc1, id_alusrc2  in  1 each  select id_shamt / id_imm instead of forwarded rs / rt
- id_regdst  in  2  00 rt, 01 rd, 10 $31, 11 $26
- id_shamt, id_imm  in  XLEN each  pre-extended operands
- id_rs, id_rt, id_rd  in  REGW each  register indices
- id_rsdata, id_rtdata  in  XLEN each  register-file data
- id_memwrite, id_regwrite  in  1 each  passthrough controls
- id_memtoreg  in  2  passthrough
- id_pc4  in  XLEN  PC+4, passthrough for jal
- fwd_we  in  NFWD  per-source write enable
- fwd_addr  in  NFWD*REGW  per-source destination
- fwd_data  in  NFWD*XLEN  per-source data
- ex_wreg  out  REGW  combinational destination, for the ID hazard unit
- out_ready  in  1  MEM accepts
- out_valid  out  1  EX/MEM entry valid
- out_alu, out_wdata, out_pc4  out  XLEN each  registered result, store data (forwarded rt), PC+4
- out_wreg  out  REGW  registered destination
- out_memwrite, out_regwrite  out  1 each  registered controls
- out_memtoreg  out  2  registered control
- mdu_busy  out  1  MDU iterating

## Operation

**Forwarding**
- Applies to each of rs and rt independently.
- Take the lowest index i where fwd_we[i] is set, fwd_addr[i] ≠ 0, and fwd_addr[i] equals the operand index.
- If no source matches, use the register-file data. Register 0 is never forwarded.

**ALU**
- ALU result is purely combinational from the selected operands.
- out_wdata always takes forwarded rt, ignoring id_alusrc2.

**MDU**
- MULT[U] and DIV[U] start the MDU on accept. The instruction itself enters EX/MEM with out_regwrite=0.
- Later independent instructions flow normally while the MDU runs.
- MFHI, MFLO, MTHI, MTLO and any MDU op presented while mdu_busy is high are held: id_ready=0 until busy clears.
- MFHI/MFLO put HI/LO on out_alu. MTHI/MTLO write forwarded rs into HI/LO on accept.
- Signed ops take magnitudes first and fix the sign at the end.
- DIV: LO=quotient, HI=remainder; the remainder takes the dividend's sign.
- Divide by zero: LO=all ones, HI=dividend; still takes full latency.

**Handshake**
- id_ready = (!out_valid | out_ready) & !interlock.
- A bundle is accepted when id_valid & id_ready & !flush.
- On accept, EX/MEM loads. If out_ready is set and nothing is accepted, out_valid clears. Otherwise EX/MEM holds unchanged.
- flush never aborts a running MDU.

**Reset**
- All out_* = 0; mdu_busy = 0; HI = LO = 0; MDU in IDLE.
- Reset mid-iteration discards the operation. HI/LO return to 0.

**MDU state machine**
- IDLE → BUSY on MDU accept; counter loads XLEN.
- BUSY decrements the counter each cycle. At 1 it writes HI/LO and returns to IDLE.

## Timing
- Forward select, ALU and ex_wreg are combinational within the cycle. EX/MEM has 1-cycle latency.
- MDU latency is exactly XLEN cycles: mdu_busy is high for cycles 1..XLEN after accept.
- HI/LO are valid and an interlocked instruction is accepted in cycle XLEN+1.
- A new MDU op may be accepted in the same cycle busy falls; back-to-back runs have no gap.
- Under out_ready=0, all out_* stay stable and the MDU keeps iterating.

## Structure
- Shared package `ex_pkg` holds:
  - ALU/MDU opcode localparams (MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO);
  - the regdst encodings;
  - the $ra/$k0 indices.
- Sub-module `ex_mdu` contains the counter, FSM, HI/LO and the shift-add/restoring datapath. It has a start/busy interface plus a HI/LO write port.
- The existing ALU is instantiated unchanged.

## Test plan
- Forwarding priority: fwd_we=2'b11, both addresses =5, data 0xAAAA/0xBBBB, rs=5, ADD with rt data 1 → out_alu=0xAAAB. Repeat with rs=0 → register-file data, no forwarding.
- Signed MULT -3 × 7, then MFLO → MFLO stalls (id_ready=0) for 32 cycles; then out_alu=0xFFFFFFEB, HI=0xFFFFFFFF.
- DIV 7 / 0, then MFHI/MFLO → HI=7, LO=0xFFFFFFFF. DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Hold: out_ready=0 for 3 cycles with ADD pending → outputs stable, id_ready=0. Then out_ready=1 → next bundle accepted that cycle.
- flush with a valid bundle → out_valid=0 next cycle. flush during a busy MULT → HI/LO still updated at cycle 32.
- rst_n asserted at cycle 10 of a DIV → mdu_busy=0 and HI=LO=0 immediately. A new MULT after release runs a full 32 cycles.
